shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
- Multi-cycle controller that performs a variable-amount logical/arithmetic left/right shift using one fixed-width step shifter (max STEP bits per cycle).
- Sequences the shift over ceil(amt/STEP) cycles; valid/ready handshake on both sides.
- Sits between an operand producer and result consumer where a full barrel shifter is too costly.

Parameters:
- W, 8, data width in bits (>= 2)
- STEP, 3, maximum shift distance applied per cycle (1 <= STEP <= W)
- AW, $clog2(W)+1, shift-amount field width (derived; must not be overridden)

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- up_valid  input  1  request valid
- up_ready  output  1  controller can accept a request
- up_data  input  W  operand
- up_amt  input  AW  shift amount, unsigned
- up_dir  input  1  0 = left, 1 = right
- up_arith  input  1  1 = sign-fill on right shift; ignored for left
- down_valid  output  1  result valid
- down_ready  input  1  consumer accepts result
- down_data  output  W  result
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous, active-low. While rst_n=0 at a rising edge: state=IDLE, down_valid=0, down_data=0, busy=0, internal data/remaining-count regs=0; up_ready=0 during the reset cycle.
- FSM states:
  - IDLE: up_ready=1. On up_valid, capture data, dir and arith, and store rem = min(up_amt, W); saturate any amount > W to W. If the clamped rem is 0, go to DONE; otherwise go to SHIFT.
  - SHIFT: up_ready=0. Each cycle apply k = min(rem, STEP) in the captured direction, then rem -= k. When rem reaches 0 after the update, go to DONE.
  - DONE: down_valid=1, down_data = shifted reg. On down_ready, go to IDLE.
- Fill rules: left shifts fill with 0; logical right shifts fill with 0; arithmetic right shifts fill with captured bit W-1. A full-width shift (W) yields all 0s, or all copies of the sign bit for arithmetic right.
- Latency: request accepted at edge E; down_valid is high after edge E+ceil(rem/STEP)+1 for rem>0, or after E+1 for rem=0.
- Throughput: one request per (ceil(rem/STEP)+2) cycles minimum.
- Backpressure: in DONE, down_data and down_valid are held stable until down_ready; up_valid is ignored (no capture) while not IDLE.
- up_* inputs are sampled only on the accept edge; later changes have no effect.
- Reset mid-SHIFT or mid-DONE: the operation is aborted and no result is produced.
- down_data is registered; there is no combinational path from up_* to down_*.

Optional Feature:
- Macro: SHIFT_SEQ_OVERLAP_EN.
- Defined: in DONE, up_ready = down_ready. A same-edge handshake on both sides retires the result and captures the new request, going to SHIFT or DONE as above and skipping IDLE. Back-to-back amt=0 requests then give one result per cycle. up_ready still depends combinationally on down_ready only.
- Undefined: up_ready=1 only in IDLE; DONE always returns to IDLE.

Test Plan (W=8, STEP=3):
- Left by 5: data 8'hB6, amt 5, dir 0 -> 2 SHIFT cycles, down_data 8'hC0; down_valid after accept edge +3.
- Logical right by 7: data 8'hF0, amt 7, dir 1, arith 0 -> 3 SHIFT cycles, down_data 8'h01.
- Arithmetic right and clamp: data 8'h90, amt 4, arith 1 -> 8'hF9. Data 8'h80, amt 12, arith 1 -> clamped to 8 -> 8'hFF. Data 8'h80, amt 12, left -> 8'h00.
- Zero amount: data 8'h5A, amt 0 -> down_valid 8'h5A one edge after accept, with no SHIFT cycles.
- Backpressure: hold down_ready=0 for 5 cycles in DONE while toggling up_valid and up_data -> down_data stable, up_ready=0, no capture. Release -> IDLE next edge.
- Reset mid-op: assert rst_n=0 for 1 cycle during SHIFT of amt 8 -> next cycle IDLE, down_valid=0, down_data=0. A new request then completes correctly.
- With the macro defined: two amt-0 requests with down_ready=1 -> results on consecutive cycles.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle variable shifter built around one step shifter
// that moves at most STEP bit positions per clock. An operand is captured on
// the upstream handshake, shifted over ceil(amt/STEP) cycles, and then held
// on the downstream side until the consumer takes it.
//
// Optional build macro: SHIFT_SEQ_OVERLAP_EN
//   Defined   : in DONE, up_ready follows down_ready. A handshake on both sides
//               at the same edge retires the result and captures the next
//               request directly, skipping IDLE.
//   Undefined : requests are accepted only in IDLE; DONE always returns to IDLE.
module shift_sequencer #(
    parameter  int W    = 8,
    parameter  int STEP = 3,
    localparam int AW   = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [W-1:0]  up_data,
    input  logic [AW-1:0] up_amt,
    input  logic          up_dir,
    input  logic          up_arith,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [W-1:0]  down_data,
    output logic          busy
);

    // Amount constants sized to the amount field so every compare and
    // subtract below stays at AW bits.
    localparam logic [AW-1:0] W_AMT    = AW'(W);
    localparam logic [AW-1:0] STEP_AMT = AW'(STEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_data;
    logic [AW-1:0]   r_rem;
    logic            r_dir;
    logic            r_arith;

    state_t          w_state_nxt;
    logic [W-1:0]    w_data_nxt;
    logic [AW-1:0]   w_rem_nxt;
    logic            w_dir_nxt;
    logic            w_arith_nxt;
    logic            w_up_ready;
    logic            w_capture;
    logic [AW-1:0]   w_k;
    logic [AW-1:0]   w_rem_after;
    logic [AW-1:0]   w_amt_clamped;

    // One step of the shifter. k never exceeds STEP, and STEP <= W, so a
    // shift of exactly W (all bits out) is the largest case; the fill mask
    // covers it because (ones >> W) is zero.
    function automatic logic [W-1:0] step_shift(
        input logic [W-1:0]  d,
        input logic [AW-1:0] k,
        input logic          dir,
        input logic          arith
    );
        logic [W-1:0] res;
        logic [W-1:0] fill_mask;
        fill_mask = ~({W{1'b1}} >> k);
        if (dir) begin
            res = d >> k;
            if (arith && d[W-1]) begin
                res = res | fill_mask;
            end
        end else begin
            res = d << k;
        end
        return res;
    endfunction

    // Amount clamp and per-cycle step size.
    assign w_amt_clamped = (up_amt > W_AMT) ? W_AMT : up_amt;
    assign w_k           = (r_rem < STEP_AMT) ? r_rem : STEP_AMT;
    assign w_rem_after   = r_rem - w_k;

    // Next-state, datapath next values and upstream ready.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_rem_nxt   = r_rem;
        w_dir_nxt   = r_dir;
        w_arith_nxt = r_arith;
        w_up_ready  = 1'b0;
        w_capture   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_up_ready = 1'b1;
                w_capture  = up_valid;
            end
            S_SHIFT: begin
                w_data_nxt = step_shift(r_data, w_k, r_dir, r_arith);
                w_rem_nxt  = w_rem_after;
                if (w_rem_after == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (down_ready) begin
                    w_state_nxt = S_IDLE;
                end
`ifdef SHIFT_SEQ_OVERLAP_EN
                w_up_ready = down_ready;
                w_capture  = down_ready && up_valid;
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A capture overrides whatever the state above chose; the new
        // operand goes straight to DONE when there is nothing to shift.
        if (w_capture) begin
            w_data_nxt  = up_data;
            w_dir_nxt   = up_dir;
            w_arith_nxt = up_arith;
            w_rem_nxt   = w_amt_clamped;
            w_state_nxt = (w_amt_clamped == '0) ? S_DONE : S_SHIFT;
        end
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand, remaining count and captured mode bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_rem   <= '0;
            r_dir   <= 1'b0;
            r_arith <= 1'b0;
        end else begin
            r_data  <= w_data_nxt;
            r_rem   <= w_rem_nxt;
            r_dir   <= w_dir_nxt;
            r_arith <= w_arith_nxt;
        end
    end

    // Outputs come from registers only, except up_ready which is held low
    // while reset is asserted.
    assign up_ready   = w_up_ready & rst_n;
    assign down_valid = (r_state == S_DONE);
    assign down_data  = r_data;
    assign busy       = (r_state != S_IDLE);

endmodule
